is_uart_rx_ctrl: RTL

IS_UART_RX_CTRL -- requirements
Module: is_uart_rx_ctrl

---
 rtl/is_uart_rx_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/is_uart_rx_ctrl.sv
// is_uart_rx_ctrl: receive-side controller that sits behind a UART RX FSM.
// It gates incoming frames with an OFF/RUN/FLUSH controller, classifies
// parity/stop errors, buffers good frames in a first-word-fall-through FIFO,
// keeps a sticky overrun flag and a saturating error counter, and raises a
// one-clock pulse when the line has stayed idle too long after a frame.
`timescale 1ns/1ps

module is_uart_rx_ctrl #(
    parameter int DEPTH         = 4,
    parameter int TIMEOUT_TICKS = 40
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     rx_ce_i,
    input  logic                     rx_data_en_i,
    input  logic [9:0]               rx_data_t_i,
    input  logic                     rxct_r_i,
    input  logic                     enable_i,
    input  logic                     drop_err_i,
    input  logic                     clr_i,
    input  logic                     m_ready_i,
    output logic                     m_valid_o,
    output logic [7:0]               m_data_o,
    output logic [1:0]               m_err_o,
    output logic [$clog2(DEPTH):0]   fifo_cnt_o,
    output logic                     overrun_o,
    output logic [7:0]               err_cnt_o,
    output logic                     timeout_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [9:0]    TO_MAX   = 10'(TIMEOUT_TICKS);
    localparam logic [9:0]    TO_LAST  = 10'(TIMEOUT_TICKS - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          accept;
    logic          flushing;
    logic          head_show;
    logic          perr;
    logic          ferr;
    logic          frame_err;
    logic          want_store;
    logic          full;
    logic          pop;
    logic          push;
    logic          ovf_set;
    logic          err_set;

    logic [9:0]    to_cnt;
    logic          to_armed;

    // Controller state register; reset always returns to OFF.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state <= ST_OFF;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: arm only while the line is idle, flush for one clock on disable.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_OFF:   if (enable_i && rxct_r_i) state_nxt = ST_RUN;
            ST_RUN:   if (!enable_i) state_nxt = ST_FLUSH;
            ST_FLUSH: state_nxt = ST_OFF;
            default:  state_nxt = ST_OFF;
        endcase
    end

    // State-dependent controls: frames accepted only in RUN, head hidden during FLUSH.
    always_comb begin
        accept    = 1'b0;
        flushing  = 1'b0;
        head_show = 1'b0;
        case (state)
            ST_RUN: begin
                accept    = rx_data_en_i;
                head_show = 1'b1;
            end
            ST_OFF: begin
                head_show = 1'b1;
            end
            ST_FLUSH: begin
                flushing = 1'b1;
            end
            default: begin
                flushing = 1'b0;
            end
        endcase
    end

    // Frame classification and push/pop/overrun decisions for the current clock.
    always_comb begin
        perr       = ~rx_data_t_i[8];
        ferr       = rx_data_t_i[9];
        frame_err  = perr | ferr;
        full       = (count == CNT_FULL);
        m_valid_o  = head_show && (count != '0);
        pop        = m_valid_o && m_ready_i;
        want_store = accept && !(frame_err && drop_err_i);
        push       = want_store && (!full || pop);
        ovf_set    = want_store && full && !pop;
        err_set    = accept && frame_err;
        m_data_o   = m_valid_o ? mem[rd_ptr][7:0] : 8'h00;
        m_err_o    = m_valid_o ? mem[rd_ptr][9:8] : 2'b00;
        fifo_cnt_o = count;
    end

    // FIFO storage; the head is read combinationally from here.
    always_ff @(posedge clk_i) begin
        if (rstn_i && push) begin
            mem[wr_ptr] <= {ferr, perr, rx_data_t_i[7:0]};
        end
    end

    // FIFO pointers and occupancy; FLUSH and reset both empty the FIFO.
    always_ff @(posedge clk_i) begin
        if (!rstn_i || flushing) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overrun flag; a new overrun in the clearing clock wins.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            overrun_o <= 1'b0;
        end else if (ovf_set) begin
            overrun_o <= 1'b1;
        end else if (clr_i) begin
            overrun_o <= 1'b0;
        end
    end

    // Saturating errored-frame counter; an error in the clearing clock leaves it at 1.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            err_cnt_o <= 8'd0;
        end else if (err_set) begin
            if (clr_i) begin
                err_cnt_o <= 8'd1;
            end else if (err_cnt_o != 8'hFF) begin
                err_cnt_o <= err_cnt_o + 8'd1;
            end
        end else if (clr_i) begin
            err_cnt_o <= 8'd0;
        end
    end

    // Idle timeout: counts strobes after a frame, fires once, re-arms on the next frame.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            to_cnt    <= 10'd0;
            to_armed  <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            if (accept) begin
                to_cnt   <= 10'd0;
                to_armed <= 1'b1;
            end else if (!rxct_r_i) begin
                to_cnt <= 10'd0;
            end else if ((state == ST_RUN) && rx_ce_i && (to_cnt != TO_MAX)) begin
                to_cnt <= to_cnt + 10'd1;
                if ((to_cnt == TO_LAST) && to_armed) begin
                    timeout_o <= 1'b1;
                    to_armed  <= 1'b0;
                end
            end
        end
    end

endmodule
